// File: rtl/div_sqrt_sequencer.sv
// Issue controller for the shared iterative mantissa divide/sqrt unit: queues tagged
// requests, launches one at a time, and returns each result on a single-entry port.
module div_sqrt_sequencer #(
  parameter int INWIDTH  = 24,
  parameter int OUTWIDTH = 24,
  parameter int REMWIDTH = (INWIDTH > OUTWIDTH) ? INWIDTH : OUTWIDTH,
  parameter int TAGWIDTH = 4,
  parameter int DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_mode,
  input  logic [TAGWIDTH-1:0]    req_tag,
  input  logic [INWIDTH-1:0]     req_a,
  input  logic [INWIDTH-1:0]     req_b,
  output logic                   unit_start,
  output logic                   unit_mode,
  output logic [INWIDTH-1:0]     unit_dividend,
  output logic [INWIDTH-1:0]     unit_divisor_radicand,
  input  logic                   unit_done,
  input  logic [OUTWIDTH-1:0]    unit_quotient_root,
  input  logic [REMWIDTH:0]      unit_remainder,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [TAGWIDTH-1:0]    rsp_tag,
  output logic                   rsp_mode,
  output logic [OUTWIDTH-1:0]    rsp_result,
  output logic                   rsp_inexact,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  typedef struct packed {
    logic                mode;
    logic [TAGWIDTH-1:0] tag;
    logic [INWIDTH-1:0]  a;
    logic [INWIDTH-1:0]  b;
  } req_t;

  typedef enum logic {IDLE, WAIT} state_t;

  req_t                fifo_mem [DEPTH];
  req_t                head;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  state_t              state;
  logic                discard;
  logic [TAGWIDTH-1:0] held_tag;
  logic                full, empty, push, issue;

  assign full      = (fifo_count == FULL_CNT);
  assign empty     = (fifo_count == '0);
  assign req_ready = !full && !flush;
  assign push      = req_valid && req_ready;
  assign head      = fifo_mem[rd_ptr];
  // Issue only when the response slot is free by the time the result returns.
  assign issue     = (state == IDLE) && !empty && (!rsp_valid || rsp_ready) && !flush;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{mode: req_mode, tag: req_tag, a: req_a, b: req_b};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr                <= '0;
      rd_ptr                <= '0;
      fifo_count            <= '0;
      state                 <= IDLE;
      discard               <= 1'b0;
      held_tag              <= '0;
      unit_start            <= 1'b0;
      unit_mode             <= 1'b0;
      unit_dividend         <= '0;
      unit_divisor_radicand <= '0;
      rsp_valid             <= 1'b0;
      rsp_tag               <= '0;
      rsp_mode              <= 1'b0;
      rsp_result            <= '0;
      rsp_inexact           <= 1'b0;
    end else begin
      unit_start <= 1'b0;
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;

      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
        rsp_valid  <= 1'b0;
      end else begin
        if (push)  wr_ptr <= wr_ptr + 1'b1;
        if (issue) rd_ptr <= rd_ptr + 1'b1;
        if (push && !issue)      fifo_count <= fifo_count + 1'b1;
        else if (issue && !push) fifo_count <= fifo_count - 1'b1;
      end

      case (state)
        IDLE: begin
          if (issue) begin
            unit_start            <= 1'b1;
            unit_mode             <= head.mode;
            unit_dividend         <= head.a;
            unit_divisor_radicand <= head.b;
            held_tag              <= head.tag;
            state                 <= WAIT;
          end
        end
        WAIT: begin
          if (unit_done) begin
            state   <= IDLE;
            discard <= 1'b0;
            // A flush landing on the done cycle drops the result directly.
            if (!discard && !flush) begin
              rsp_valid   <= 1'b1;
              rsp_tag     <= held_tag;
              rsp_mode    <= unit_mode;
              rsp_result  <= unit_quotient_root;
              rsp_inexact <= |unit_remainder;
            end
          end else if (flush) begin
            discard <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_sqrt_sequencer.sv
// Directed bench for div_sqrt_sequencer with a behavioural iterative divide/sqrt unit.
module tb_div_sqrt_sequencer;
  localparam int LAT = 25;

  logic        clk = 1'b0;
  logic        reset, flush, req_valid, req_ready, req_mode;
  logic [3:0]  req_tag;
  logic [23:0] req_a, req_b;
  logic        unit_start, unit_mode, unit_done;
  logic [23:0] unit_dividend, unit_divisor_radicand, unit_quotient_root;
  logic [24:0] unit_remainder;
  logic        rsp_valid, rsp_ready, rsp_mode, rsp_inexact;
  logic [3:0]  rsp_tag;
  logic [23:0] rsp_result;
  logic [2:0]  fifo_count;

  div_sqrt_sequencer dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_tag(req_tag), .req_a(req_a), .req_b(req_b),
    .unit_start(unit_start), .unit_mode(unit_mode), .unit_dividend(unit_dividend),
    .unit_divisor_radicand(unit_divisor_radicand), .unit_done(unit_done),
    .unit_quotient_root(unit_quotient_root), .unit_remainder(unit_remainder),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
    .rsp_mode(rsp_mode), .rsp_result(rsp_result), .rsp_inexact(rsp_inexact),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, c0 = 0;
  int n_start = 0, n_done = 0, n_rspv = 0;
  bit inflight = 0;

  typedef struct packed {
    logic [3:0]  tag;
    logic        mode;
    logic [23:0] res;
    logic        inx;
  } rsp_t;
  rsp_t rq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Behavioural unit: 1.23 mantissas, done LAT cycles after the start it sees.
  int          m_cnt;
  bit          m_busy;
  logic [63:0] m_n, m_q, m_r, m_t;
  initial begin
    unit_done = 1'b0; unit_quotient_root = '0; unit_remainder = '0;
    m_busy = 0; m_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        m_busy = 0; unit_done = 1'b0;
      end else begin
        unit_done = 1'b0;
        if (m_busy) begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_busy = 0; unit_done = 1'b1;
            unit_quotient_root = m_q[23:0]; unit_remainder = m_r[24:0];
          end
        end
        if (unit_start) begin
          m_busy = 1; m_cnt = LAT;
          if (!unit_mode) begin
            m_n = {40'd0, unit_dividend} << 23;
            m_q = m_n / {40'd0, unit_divisor_radicand};
            m_r = m_n % {40'd0, unit_divisor_radicand};
          end else begin
            m_n = {40'd0, unit_divisor_radicand} << 23;
            m_q = '0;
            for (int i = 25; i >= 0; i--) begin
              m_t = m_q | (64'd1 << i);
              if (m_t * m_t <= m_n) m_q = m_t;
            end
            m_r = m_n - m_q * m_q;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset) inflight = 0;
    else begin
      if (unit_start) begin
        chk("start_while_inflight", inflight, 0);
        inflight = 1; n_start++;
      end
      if (unit_done) begin inflight = 0; n_done++; end
      if (rsp_valid) n_rspv++;
      if (rsp_valid && rsp_ready) rq.push_back('{tag: rsp_tag, mode: rsp_mode, res: rsp_result, inx: rsp_inexact});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic send(input logic [3:0] tag, input logic mode, input logic [23:0] a, input logic [23:0] b);
    req_valid = 1'b1; req_tag = tag; req_mode = mode; req_a = a; req_b = b;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (req_ready) begin
        tick(); req_valid = 1'b0; c0 = cyc;
        return;
      end
      tick();
    end
    chk("req_timeout", 1, 0);
    req_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag, output int c);
    c = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (unit_start) begin c = cyc - c0 + 1; break; end
    end
    if (c < 0) chk({tag, "_timeout"}, 1, 0);
  endtask

  task automatic wait_rsp(input string tag, output int c);
    c = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (rsp_valid) begin c = cyc - c0 + 1; break; end
    end
    if (c < 0) chk({tag, "_timeout"}, 1, 0);
  endtask

  task automatic wait_rq(input string tag, input int want);
    for (int n = 0; n < 800 && rq.size() < want; n++) @(negedge clk);
    chk({tag, "_count"}, rq.size(), want);
  endtask

  logic [3:0]  e_tag [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
  logic        e_mode[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [23:0] e_res [5] = '{24'hA00000, 24'h900000, 24'h666666, 24'h800000, 24'h555555};
  logic        e_inx [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int c, s, v, d;
    bit stable, hit;
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_mode = 1'b0;
    req_tag = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_unit_start", unit_start, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_unit_dividend", unit_dividend, 0);
    chk("rst_rsp_result", rsp_result, 0);
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", req_ready, 1);
    tick();

    // single divide, latency
    send(4'd3, 1'b0, 24'hC00000, 24'h800000);
    wait_start("t1_start", c);
    chk("t1_start_cyc", c, 2);
    chk("t1_unit_mode", unit_mode, 0);
    chk("t1_unit_dividend", unit_dividend, 24'hC00000);
    chk("t1_unit_divisor", unit_divisor_radicand, 24'h800000);
    wait_rsp("t1_rsp", c);
    chk("t1_rsp_cyc", c, 28);
    chk("t1_rsp_tag", rsp_tag, 3);
    chk("t1_rsp_mode", rsp_mode, 0);
    chk("t1_rsp_result", rsp_result, 24'hC00000);
    chk("t1_rsp_inexact", rsp_inexact, 0);
    tick(); tick(); rq.delete();

    // five back-to-back, FIFO fills
    send(4'd0, 1'b0, 24'hA00000, 24'h800000);
    send(4'd1, 1'b1, 24'h000000, 24'hA20000);
    send(4'd2, 1'b0, 24'h800000, 24'hA00000);
    send(4'd3, 1'b1, 24'h000000, 24'h800000);
    send(4'd4, 1'b0, 24'h800000, 24'hC00000);
    @(negedge clk);
    chk("t2_count_full", fifo_count, 4);
    chk("t2_ready_low", req_ready, 0);
    wait_rq("t2_rsp", 5);
    for (int i = 0; i < 5 && i < rq.size(); i++) begin
      chk($sformatf("t2_tag%0d", i), rq[i].tag, e_tag[i]);
      chk($sformatf("t2_mode%0d", i), rq[i].mode, e_mode[i]);
      chk($sformatf("t2_res%0d", i), rq[i].res, e_res[i]);
      chk($sformatf("t2_inx%0d", i), rq[i].inx, e_inx[i]);
    end

    // response back-pressure
    tick(); rq.delete(); rsp_ready = 1'b0;
    send(4'd5, 1'b0, 24'hC00000, 24'h800000);
    send(4'd6, 1'b1, 24'h000000, 24'h800000);
    send(4'd7, 1'b1, 24'h000000, 24'hA20000);
    wait_rsp("t3_rsp", c);
    s = n_start; stable = 1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_tag != 4'd5 || rsp_result != 24'hC00000) stable = 0;
    end
    chk("t3_held_stable", stable, 1);
    chk("t3_no_issue", n_start, s);
    chk("t3_queued", fifo_count, 2);
    tick(); rsp_ready = 1'b1;
    @(negedge clk);
    chk("t3_no_start_yet", unit_start, 0);
    @(negedge clk);
    chk("t3_start_after_hs", unit_start, 1);
    wait_rq("t3_rsp", 3);
    if (rq.size() == 3) begin
      chk("t3_tag0", rq[0].tag, 5);
      chk("t3_tag1", rq[1].tag, 6);
      chk("t3_tag2", rq[2].tag, 7);
      chk("t3_res2", rq[2].res, 24'h900000);
    end

    // flush during WAIT with two queued
    tick(); rq.delete();
    send(4'd8, 1'b0, 24'hA00000, 24'h800000);
    send(4'd9, 1'b1, 24'h000000, 24'h800000);
    send(4'd10, 1'b0, 24'h800000, 24'hC00000);
    @(negedge clk);
    chk("t4_queued", fifo_count, 2);
    tick(); flush = 1'b1;
    @(negedge clk);
    chk("t4_ready_flush", req_ready, 0);
    tick(); flush = 1'b0;
    d = n_done; v = n_rspv; s = n_start;
    @(negedge clk);
    chk("t4_count_flushed", fifo_count, 0);
    for (int n = 0; n < 100 && n_done == d; n++) @(negedge clk);
    chk("t4_done_seen", n_done, d + 1);
    repeat (5) @(negedge clk);
    chk("t4_no_rsp", n_rspv, v);
    chk("t4_no_issue", n_start, s);
    tick();
    send(4'd11, 1'b1, 24'h000000, 24'hA20000);
    wait_start("t4_next_start", c);
    chk("t4_next_start_cyc", c, 2);
    wait_rsp("t4_next_rsp", c);
    chk("t4_next_rsp_cyc", c, 28);
    chk("t4_next_tag", rsp_tag, 11);
    chk("t4_next_result", rsp_result, 24'h900000);

    // flush coincident with req_valid and unit_done
    tick();
    send(4'd12, 1'b0, 24'hC00000, 24'h800000);
    wait_start("t5_start", c);
    hit = 0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (unit_done) begin hit = 1; break; end
    end
    chk("t5_done_found", hit, 1);
    flush = 1'b1; req_valid = 1'b1; req_tag = 4'd13; req_mode = 1'b0;
    req_a = 24'hA00000; req_b = 24'h800000;
    @(negedge clk);
    chk("t5_ready_low", req_ready, 0);
    v = n_rspv; s = n_start;
    tick(); flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("t5_count", fifo_count, 0);
    repeat (5) @(negedge clk);
    chk("t5_no_rsp", n_rspv, v);
    chk("t5_no_issue", n_start, s);
    tick();
    send(4'd14, 1'b1, 24'h000000, 24'h800000);
    wait_start("t5_next_start", c);
    chk("t5_next_start_cyc", c, 2);
    wait_rsp("t5_next_rsp", c);
    chk("t5_next_rsp_cyc", c, 28);
    chk("t5_next_tag", rsp_tag, 14);
    chk("t5_next_result", rsp_result, 24'h800000);

    // reset mid-WAIT
    tick();
    send(4'd15, 1'b0, 24'h800000, 24'hA00000);
    wait_start("t6_start", c);
    repeat (5) @(negedge clk);
    tick(); reset = 1'b1; #1;
    chk("t6_unit_start", unit_start, 0);
    chk("t6_unit_dividend", unit_dividend, 0);
    chk("t6_unit_divisor", unit_divisor_radicand, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_rsp_tag", rsp_tag, 0);
    chk("t6_rsp_mode", rsp_mode, 0);
    chk("t6_rsp_result", rsp_result, 0);
    chk("t6_fifo_count", fifo_count, 0);
    tick(); tick(); reset = 1'b0;
    send(4'd1, 1'b1, 24'h000000, 24'hA20000);
    wait_start("t6_next_start", c);
    chk("t6_next_start_cyc", c, 2);
    wait_rsp("t6_next_rsp", c);
    chk("t6_next_rsp_cyc", c, 28);
    chk("t6_next_tag", rsp_tag, 1);
    chk("t6_next_result", rsp_result, 24'h900000);
    chk("t6_next_inexact", rsp_inexact, 0);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/div_sqrt_sequencer.md
# div_sqrt_sequencer

Issue controller for the shared iterative mantissa divide/square-root unit in the FPU. Accepts tagged requests from the FPU issue stage into a small FIFO, launches them one at a time into the iterative unit (start/mode/operands), captures each result on the unit's done pulse, and presents it with its tag on a single-entry valid/ready response port. Supports pipeline flush, with the result of an in-flight operation discarded.

## Interface
- INWIDTH, 24, operand mantissa width (1.xxx form)
- OUTWIDTH, 24, quotient/root width
- REMWIDTH, max(INWIDTH,OUTWIDTH), unit remainder is REMWIDTH+1 bits
- TAGWIDTH, 4, request tag width
- DEPTH, 4, request FIFO entries (power of 2, ≥2)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  drop queued, held and in-flight work
- req_valid  in  1  request present
- req_ready  out  1  FIFO not full and flush low
- req_mode  in  1  0 = divide, 1 = square root
- req_tag  in  TAGWIDTH  returned with result
- req_a  in  INWIDTH  dividend (ignored for sqrt)
- req_b  in  INWIDTH  divisor or radicand
- unit_start  out  1  one-cycle launch pulse, registered
- unit_mode  out  1  registered mode for launch
- unit_dividend  out  INWIDTH  registered
- unit_divisor_radicand  out  INWIDTH  registered
- unit_done  in  1  one-cycle result pulse from unit
- unit_quotient_root  in  OUTWIDTH  valid when unit_done
- unit_remainder  in  REMWIDTH+1  valid when unit_done
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts
- rsp_tag  out  TAGWIDTH
- rsp_mode  out  1
- rsp_result  out  OUTWIDTH  quotient or root
- rsp_inexact  out  1  OR-reduction of unit_remainder
- fifo_count  out  $clog2(DEPTH)+1  queued requests

## Operation
- Reset: FIFO empty, fifo_count 0, state IDLE, discard 0; unit_start, unit_mode, unit_dividend, unit_divisor_radicand, rsp_valid, rsp_tag, rsp_mode, rsp_result, rsp_inexact all 0. req_ready 1 after reset releases.
- FIFO: write on req_valid & req_ready; read on issue. Simultaneous read and write when full is not allowed (req_ready is low when full); simultaneous read and write when non-full is allowed, and count is unchanged. Pointers wrap modulo DEPTH.
- States: IDLE, WAIT.
- IDLE: issue when FIFO non-empty and (rsp_valid==0 or rsp_ready==1) and flush==0. Issue pops the head, registers unit_start=1 with the mode and operands, sets the held tag/mode, and moves to WAIT. unit_start is high for exactly one cycle. The operand outputs hold their value until the next issue.
- WAIT: on unit_done, go to IDLE. If discard==0, load rsp_result, rsp_inexact, rsp_tag and rsp_mode, and set rsp_valid. Clear discard.
- Issue rule guarantees the response slot is free when done arrives; there is never more than one operation in flight.
- Response: rsp_valid stays high with stable data until rsp_ready; it clears on the handshake cycle.
- flush: empties the FIFO, clears rsp_valid, and blocks issue and enqueue that cycle. If in WAIT (or issuing that cycle is impossible since issue is blocked), set discard=1. The state stays WAIT until unit_done, and that result is dropped.
- flush with req_valid: request dropped (req_ready low). flush with unit_done in WAIT: result dropped, go to IDLE, discard stays 0.
- unit_done in IDLE: ignored.
- Reset mid-operation: everything returns to reset values immediately. The unit shares the reset.

## Timing
- Issue decision in cycle N → unit_start high in cycle N+1.
- Idle pipeline, OUTWIDTH=24: request handshake in cycle 0 → unit_start in cycle 2 → unit_done in cycle 27 → rsp_valid in cycle 28. Total latency is OUTWIDTH+4.
- Back-to-back throughput: the next unit_start comes 2 cycles after unit_done (IDLE re-entry, then the registered start).
- req_ready is combinational from FIFO full and flush. There is no combinational path from rsp_ready to req_ready.

## Test plan
- Single divide, a=0xC00000, b=0x800000, tag 3 → unit_start in cycle 2, rsp_valid in cycle 28 with rsp_tag 3, rsp_mode 0, rsp_result from the unit model, rsp_inexact 0.
- Five back-to-back requests (tags 0–4, mixed modes) with DEPTH 4 → req_ready drops when fifo_count reaches 4; responses arrive in tag order 0..4; unit_start is never high while an operation is in flight.
- rsp_ready held low for 50 cycles after the first result, with two requests queued → no second unit_start until rsp_ready rises; the held response stays stable; the next unit_start follows the handshake in the next cycle.
- flush during WAIT with 2 queued requests → fifo_count 0 next cycle; unit_done from the in-flight op produces no rsp_valid; the next request after that completes normally.
- flush coincident with req_valid and with unit_done → the request is not enqueued, no response is produced, and the state returns to IDLE.
- reset asserted mid-WAIT → all outputs are 0 immediately; a request after release completes with normal latency.
